flag_stack_unit: RTL and testbench

FLAG_STACK_UNIT -- requirements
Module: flag_stack_unit

---
 rtl/flag_stack_unit_pkg.sv | 21 ++
 rtl/flag_stack_unit_mem.sv | 37 +++
 rtl/flag_stack_unit.sv | 131 +++++++++++++
 tb/tb_flag_stack_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/flag_stack_unit_pkg.sv
// ---------------------------------------------------------------------------
// flag_stack_unit_pkg
// Shared SAYEH definitions for the {C,Z} flag stack: restore-sequence FSM
// encoding, the default stack depth, and the flag packing helper.
// ---------------------------------------------------------------------------
package flag_stack_unit_pkg;

    localparam int FSU_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP_RD = 2'd1,
        POP_LD = 2'd2
    } fsu_state_e;

    // Stack entry layout: bit 1 = carry, bit 0 = zero.
    function automatic logic [1:0] pack_flags(input logic c, input logic z);
        return {c, z};
    endfunction

endpackage

// File: rtl/flag_stack_unit_mem.sv
// ---------------------------------------------------------------------------
// flag_lifo_mem
// DEPTH x 2-bit storage for saved {C,Z} pairs. Synchronous write on the
// falling clock edge (matching the CPU status register), combinational read.
// Ports:
//   clk    : CPU clock (falling edge active)
//   we     : write enable
//   waddr  : write address
//   wdata  : {C,Z} to store
//   raddr  : read address
//   rdata  : {C,Z} at raddr
// ---------------------------------------------------------------------------
module flag_lifo_mem
    import flag_stack_unit_pkg::*;
#(
    parameter int DEPTH = FSU_DEPTH_DEFAULT,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [1:0]    rdata
);

    logic [1:0] mem [DEPTH];

    always_ff @(negedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/flag_stack_unit.sv
// ---------------------------------------------------------------------------
// flag_stack_unit
// LIFO of {C,Z} flag pairs for call/interrupt entry and return. A push saves
// the live flags in one cycle; a pop runs a short restore sequence that
// presents the saved flags on Cin_out/Zin_out and strobes SRload_out so the
// status register reloads them two edges after the pop was sampled.
// All state changes on the falling edge of clk, like the status register.
// Ports:
//   clk           : CPU clock (falling edge active)
//   ExternalReset : synchronous active-high reset
//   Cflag, Zflag  : live carry / zero from the status register
//   push, pop     : save / restore requests (honoured only when idle)
//   clr_err       : clears the sticky overflow / underflow flags
//   Cin_out       : restored carry to status register
//   Zin_out       : restored zero to status register
//   SRload_out    : one-cycle load strobe to status register
//   busy          : restore sequence in progress
//   full, empty   : occupancy flags
//   level         : number of entries held
//   overflow      : sticky, push attempted while full
//   underflow     : sticky, pop attempted while empty
// ---------------------------------------------------------------------------
module flag_stack_unit
    import flag_stack_unit_pkg::*;
#(
    parameter int DEPTH = FSU_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     ExternalReset,
    input  logic                     Cflag,
    input  logic                     Zflag,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr_err,
    output logic                     Cin_out,
    output logic                     Zin_out,
    output logic                     SRload_out,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = $clog2(DEPTH) + 1;

    fsu_state_e     state;
    logic [SPW-1:0] sp;
    logic           we;
    logic [AW-1:0]  waddr;
    logic [AW-1:0]  raddr;
    logic [1:0]     rdata;

    assign level = sp;
    assign empty = (sp == '0);
    assign full  = (sp == SPW'(DEPTH));
    assign busy  = (state != IDLE);

    // Write happens on the same edge that bumps sp, so the entry lands at
    // the old top-of-stack index.
    assign we    = (state == IDLE) && push && !full && !ExternalReset;
    assign waddr = sp[AW-1:0];
    // Top entry sits one below sp; the value is only used when sp != 0.
    assign raddr = AW'(sp - SPW'(1));

    flag_lifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (pack_flags(Cflag, Zflag)),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(negedge clk) begin
        if (ExternalReset) begin
            state      <= IDLE;
            sp         <= '0;
            Cin_out    <= 1'b0;
            Zin_out    <= 1'b0;
            SRload_out <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            SRload_out <= 1'b0;
            // Clear first so an error event later in this block overrides it.
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            case (state)
                IDLE: begin
                    // Push has priority; a coincident pop is silently dropped.
                    if (push) begin
                        if (!full) begin
                            sp <= sp + SPW'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else if (pop) begin
                        if (!empty) begin
                            sp      <= sp - SPW'(1);
                            Cin_out <= rdata[1];
                            Zin_out <= rdata[0];
                            state   <= POP_RD;
                        end else begin
                            underflow <= 1'b1;
                        end
                    end
                end
                POP_RD: begin
                    // Strobe is registered so it is high for the whole POP_LD cycle.
                    SRload_out <= 1'b1;
                    state      <= POP_LD;
                end
                POP_LD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flag_stack_unit.sv
module tb_flag_stack_unit;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       ExternalReset = 1'b0;
    logic       Cflag = 1'b0;
    logic       Zflag = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clr_err = 1'b0;
    logic       Cin_out, Zin_out, SRload_out, busy, full, empty;
    logic [3:0] level;
    logic       overflow, underflow;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a plain queue of saved {C,Z} pairs plus a countdown
    // of edges remaining in a restore (2 after an accepted pop; the load
    // strobe is expected while exactly 1 edge remains).
    logic [1:0] mq[$];
    logic       m_c = 1'b0, m_z = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
    int         m_rcnt = 0;

    flag_stack_unit #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .ExternalReset (ExternalReset),
        .Cflag         (Cflag),
        .Zflag         (Zflag),
        .push          (push),
        .pop           (pop),
        .clr_err       (clr_err),
        .Cin_out       (Cin_out),
        .Zin_out       (Zin_out),
        .SRload_out    (SRload_out),
        .busy          (busy),
        .full          (full),
        .empty         (empty),
        .level         (level),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic p, input logic po, input logic cl,
                              input logic rs, input logic c, input logic z);
        logic [1:0] v;
        if (rs) begin
            mq.delete();
            m_c = 1'b0; m_z = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_rcnt = 0;
        end else begin
            if (cl) begin
                m_ovf = 1'b0; m_unf = 1'b0;
            end
            if (m_rcnt > 0) begin
                m_rcnt--;
            end else if (p) begin
                if (mq.size() < DEPTH) mq.push_back({c, z});
                else m_ovf = 1'b1;
            end else if (po) begin
                if (mq.size() > 0) begin
                    v = mq.pop_back();
                    m_c = v[1]; m_z = v[0]; m_rcnt = 2;
                end else begin
                    m_unf = 1'b1;
                end
            end
        end
    endtask

    // Drive inputs mid-cycle (rising edge), let the falling edge act, and
    // return at the next rising edge where outputs are stable.
    task automatic tick(input logic p, input logic po, input logic cl,
                        input logic rs, input logic c, input logic z);
        push = p; pop = po; clr_err = cl; ExternalReset = rs; Cflag = c; Zflag = z;
        model_edge(p, po, cl, rs, c, z);
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        n_chk++;
        if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_chk++;
        if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_occ: got empty=%b full=%b want 1 0", empty, full); end
        n_chk++;
        if ({SRload_out, busy, overflow, underflow, Cin_out, Zin_out} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got srl=%b busy=%b ovf=%b unf=%b c=%b z=%b want all 0",
                     SRload_out, busy, overflow, underflow, Cin_out, Zin_out);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (SRload_out !== 1'b0) begin n_fail++; $display("FAIL reset_post_srl: got %b want 0", SRload_out); end
    endtask

    task automatic test_single();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_chk++;
        if (level !== 4'd1 || empty !== 1'b0) begin n_fail++; $display("FAIL single_push: got level=%0d empty=%b want 1 0", level, empty); end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_chk++;
        if ({busy, SRload_out, Cin_out, Zin_out} !== 4'b1010) begin
            n_fail++; $display("FAIL single_pop_n: got busy=%b srl=%b c=%b z=%b want 1 0 1 0", busy, SRload_out, Cin_out, Zin_out);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if ({busy, SRload_out, Cin_out, Zin_out} !== 4'b1110) begin
            n_fail++; $display("FAIL single_pop_n1: got busy=%b srl=%b c=%b z=%b want 1 1 1 0", busy, SRload_out, Cin_out, Zin_out);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if ({busy, SRload_out, level, empty} !== {2'b00, 4'd0, 1'b1}) begin
            n_fail++; $display("FAIL single_pop_n2: got busy=%b srl=%b level=%0d empty=%b want 0 0 0 1", busy, SRload_out, level, empty);
        end
    endtask

    task automatic test_fill();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, i[1], i[0]);
        end
        n_chk++;
        if (full !== 1'b1 || level !== 4'd8) begin n_fail++; $display("FAIL fill_full: got full=%b level=%0d want 1 8", full, level); end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_chk++;
        if (overflow !== 1'b1 || level !== 4'd8) begin n_fail++; $display("FAIL fill_ovf: got ovf=%b level=%0d want 1 8", overflow, level); end
        for (int i = 7; i >= 0; i--) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            n_chk++;
            if (Cin_out !== i[1] || Zin_out !== i[0] || level !== 4'(i)) begin
                n_fail++; $display("FAIL fill_pop%0d: got c=%b z=%b level=%0d want %b %b %0d", i, Cin_out, Zin_out, level, i[1], i[0], i);
            end
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_chk++;
            if (SRload_out !== 1'b1) begin n_fail++; $display("FAIL fill_srl%0d: got %b want 1", i, SRload_out); end
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        n_chk++;
        if (empty !== 1'b1 || SRload_out !== 1'b0) begin n_fail++; $display("FAIL fill_empty: got empty=%b srl=%b want 1 0", empty, SRload_out); end
    endtask

    task automatic test_underflow();
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (underflow !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL unf_set: got unf=%b busy=%b want 1 0", underflow, busy); end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (SRload_out !== 1'b0) begin n_fail++; $display("FAIL unf_srl: got %b want 0", SRload_out); end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (underflow !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL unf_clr: got unf=%b ovf=%b want 0 0", underflow, overflow); end
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_clr_collide: got %b want 1", underflow); end
    endtask

    task automatic test_push_pop_same();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        n_chk++;
        if (level !== 4'd3 || busy !== 1'b0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL pp_same: got level=%0d busy=%b unf=%b want 3 0 0", level, busy, underflow);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (SRload_out !== 1'b0) begin n_fail++; $display("FAIL pp_same_srl: got %b want 0", SRload_out); end
    endtask

    task automatic test_push_during_pop();
        // Stack holds 3 entries from the previous scenario; top is {1,0}.
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_chk++;
        if (level !== 4'd2 || SRload_out !== 1'b1) begin n_fail++; $display("FAIL pdp_rd: got level=%0d srl=%b want 2 1", level, SRload_out); end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_chk++;
        if (level !== 4'd2 || busy !== 1'b0 || Cin_out !== 1'b1 || Zin_out !== 1'b0) begin
            n_fail++; $display("FAIL pdp_done: got level=%0d busy=%b c=%b z=%b want 2 0 1 0", level, busy, Cin_out, Zin_out);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (SRload_out !== 1'b1) begin n_fail++; $display("FAIL rmid_ld: got %b want 1", SRload_out); end
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_chk++;
        if (SRload_out !== 1'b0 || level !== 4'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rmid_rst: got srl=%b level=%0d busy=%b want 0 0 0", SRload_out, level, busy);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (SRload_out !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_post: got srl=%b busy=%b want 0 0", SRload_out, busy); end
    endtask

    task automatic test_random();
        logic [12:0] got, exp;
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            tick(($urandom % 5) < 2, ($urandom % 5) < 2, ($urandom % 12) == 0,
                 ($urandom % 80) == 0, 1'($urandom), 1'($urandom));
            got = {level, empty, full, busy, SRload_out, overflow, underflow, Cin_out, Zin_out};
            exp = {4'(mq.size()), mq.size() == 0, mq.size() == DEPTH, m_rcnt != 0,
                   m_rcnt == 1, m_ovf, m_unf, m_c, m_z};
            n_chk++;
            if (got !== exp) begin
                n_fail++; $display("FAIL random_cyc%0d: got %013b want %013b", i, got, exp);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        test_reset();
        test_single();
        test_fill();
        test_underflow();
        test_push_pop_same();
        test_push_during_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
